// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared types and helpers for the serial feeder / detector pair
package fsm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Zero or out-of-range lengths mean "send the whole word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel-to-serial feeder with framing strobes and word count
module serial_bit_feeder
  import fsm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH+1)-1:0] len_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       out,
  output logic                       bit_valid,
  output logic                       last_bit,
  output logic                       busy,
  output logic [CNT_W-1:0]           words_sent
);

  localparam int LW = $clog2(WIDTH+1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [LW-1:0]    cnt, cnt_nx;
  logic             out_nx, bit_valid_nx, last_bit_nx, busy_nx;
  logic [CNT_W-1:0] words_nx;

  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] aligned;
  logic             accept;

  // Ready only depends on registered state, so data_in/len_in never reach an output.
  assign data_ready = ((state == IDLE) || last_bit) && !reset;
  assign accept     = data_valid && data_ready;

  // Normalise the length and align the word so the first bit sits at the shift end.
  always_comb begin
    len_eff = LW'(eff_len(32'(len_in), WIDTH));
    if (MSB_FIRST != 0) aligned = data_in << (WIDTH - int'(len_eff));
    else                aligned = data_in;
  end

  // Next-state and next-output logic: load on accept, shift otherwise, drop to idle after the last bit.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    cnt_nx       = cnt;
    out_nx       = out;
    bit_valid_nx = bit_valid;
    last_bit_nx  = last_bit;
    busy_nx      = busy;
    words_nx     = words_sent;

    if ((state == SHIFT) && last_bit) words_nx = words_sent + CNT_W'(1);

    if (accept) begin
      state_nx     = SHIFT;
      busy_nx      = 1'b1;
      bit_valid_nx = 1'b1;
      cnt_nx       = len_eff - LW'(1);
      last_bit_nx  = (len_eff == LW'(1));
      if (MSB_FIRST != 0) begin
        out_nx   = aligned[WIDTH-1];
        shreg_nx = aligned << 1;
      end else begin
        out_nx   = aligned[0];
        shreg_nx = aligned >> 1;
      end
    end else if (state == SHIFT) begin
      if (!last_bit) begin
        cnt_nx      = cnt - LW'(1);
        last_bit_nx = (cnt == LW'(1));
        if (MSB_FIRST != 0) begin
          out_nx   = shreg[WIDTH-1];
          shreg_nx = shreg << 1;
        end else begin
          out_nx   = shreg[0];
          shreg_nx = shreg >> 1;
        end
      end else begin
        state_nx     = IDLE;
        busy_nx      = 1'b0;
        bit_valid_nx = 1'b0;
        last_bit_nx  = 1'b0;
        out_nx       = IDLE_LEVEL;
        cnt_nx       = '0;
        shreg_nx     = '0;
      end
    end
  end

  // State and output registers; reset abandons any word in flight at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      out        <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      last_bit   <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      out        <= out_nx;
      bit_valid  <= bit_valid_nx;
      last_bit   <= last_bit_nx;
      busy       <= busy_nx;
      words_sent <= words_nx;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - directed self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // default instance: WIDTH=8, MSB first, 16-bit counter
  logic [7:0]  data_in = '0;
  logic [3:0]  len_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, out, bit_valid, last_bit, busy;
  logic [15:0] words_sent;

  // LSB-first instance with a 4-bit counter
  logic [7:0]  data_in1 = '0;
  logic [3:0]  len_in1 = '0;
  logic        data_valid1 = 1'b0;
  logic        data_ready1, out1, bit_valid1, last_bit1, busy1;
  logic [3:0]  words_sent1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_bit_feeder u_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .len_in(len_in),
    .data_valid(data_valid), .data_ready(data_ready), .out(out),
    .bit_valid(bit_valid), .last_bit(last_bit), .busy(busy), .words_sent(words_sent)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .CNT_W(4)) u_lsb (
    .clock(clock), .reset(reset), .data_in(data_in1), .len_in(len_in1),
    .data_valid(data_valid1), .data_ready(data_ready1), .out(out1),
    .bit_valid(bit_valid1), .last_bit(last_bit1), .busy(busy1), .words_sent(words_sent1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the feeder idle; exp_bits[n-1] is the first bit on the wire.
  task automatic send_word(input logic [7:0] d, input logic [3:0] l,
                           input logic [7:0] exp_bits, input int n, input int ws_exp);
    data_in = d; len_in = l; data_valid = 1'b1;
    check("ready_idle", data_ready, 1);
    @(negedge clock);
    data_valid = 1'b0; data_in = ~d; len_in = 4'd3;
    for (int i = 0; i < n; i++) begin
      check("out", out, exp_bits[n-1-i]);
      check("bit_valid", bit_valid, 1);
      check("busy", busy, 1);
      check("last_bit", last_bit, (i == n-1));
      check("ready_shift", data_ready, (i == n-1));
      @(negedge clock);
    end
    check("idle_bit_valid", bit_valid, 0);
    check("idle_out", out, 0);
    check("idle_busy", busy, 0);
    check("words_sent", words_sent, ws_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_a;
    // reset held from time 0
    @(negedge clock);
    check("rst_out", out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_last_bit", last_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    check("rst_ready", data_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", data_ready, 1);

    // single full-length word
    send_word(8'b1011_0010, 4'd8, 8'b1011_0010, 8, 1);

    // back-to-back: A5/len4 -> 0101, then 03/len2 -> 11
    exp_a = 4'b0101;
    data_in = 8'hA5; len_in = 4'd4; data_valid = 1'b1;
    check("b2b_ready_idle", data_ready, 1);
    @(negedge clock);
    data_in = 8'h03; len_in = 4'd2;
    for (int i = 0; i < 4; i++) begin
      check("b2b_a_out", out, exp_a[3-i]);
      check("b2b_a_valid", bit_valid, 1);
      check("b2b_a_last", last_bit, (i == 3));
      check("b2b_a_ready", data_ready, (i == 3));
      @(negedge clock);
    end
    data_valid = 1'b0; data_in = 8'h00; len_in = 4'd7;
    check("b2b_b0_out", out, 1);
    check("b2b_b0_valid", bit_valid, 1);
    check("b2b_b0_last", last_bit, 0);
    check("b2b_b0_ready", data_ready, 0);
    check("b2b_words_mid", words_sent, 2);
    @(negedge clock);
    check("b2b_b1_out", out, 1);
    check("b2b_b1_last", last_bit, 1);
    @(negedge clock);
    check("b2b_idle_valid", bit_valid, 0);
    check("b2b_words", words_sent, 3);

    // length edge cases
    send_word(8'h01, 4'd1, 8'h01, 1, 4);
    send_word(8'h96, 4'd0, 8'h96, 8, 5);
    send_word(8'b0001_0110, 4'd5, 8'b0001_0110, 5, 6);

    // reset in the middle of a word
    data_in = 8'hFF; len_in = 4'd8; data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_bit_valid_before", bit_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_words", words_sent, 0);
    check("mid_rst_ready", data_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_post_ready", data_ready, 1);
    check("mid_post_valid", bit_valid, 0);
    check("mid_post_words", words_sent, 0);

    // LSB-first: 8'h01 -> 1 then seven 0s
    data_in1 = 8'h01; len_in1 = 4'd8; data_valid1 = 1'b1;
    @(negedge clock);
    data_valid1 = 1'b0; data_in1 = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      check("lsb_out", out1, (i == 0));
      check("lsb_valid", bit_valid1, 1);
      check("lsb_last", last_bit1, (i == 7));
      @(negedge clock);
    end
    check("lsb_idle_valid", bit_valid1, 0);
    check("lsb_words", words_sent1, 1);

    // 16 more single-bit words back-to-back -> 17 total wraps a 4-bit count to 1
    data_in1 = 8'h00; len_in1 = 4'd1; data_valid1 = 1'b1;
    repeat (16) @(negedge clock);
    data_valid1 = 1'b0;
    check("wrap_last", last_bit1, 1);
    check("wrap_busy", busy1, 1);
    check("wrap_words_mid", words_sent1, 0);
    @(negedge clock);
    check("wrap_words", words_sent1, 1);
    check("wrap_idle_ready", data_ready1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage of the serial sequence-detector FSM. Accepts parallel words over a valid/ready handshake.
- Shifts each word out one bit per clock on `out`, which drives the detector's `in` directly.
- Supports variable word length, selectable bit order, and back-to-back words with no idle gap.
- Provides per-bit framing strobes and a wrapping count of words sent.

Parameters:
- WIDTH, 8, maximum word length in bits (≥2).
- MSB_FIRST, 1, 1 = send data_in[len-1] first; 0 = send data_in[0] first.
- IDLE_LEVEL, 0, value driven on `out` when no bit is being sent.
- CNT_W, 16, width of words_sent.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  word to serialize; only bits [len-1:0] are used.
- len_in  in  $clog2(WIDTH+1)  bits to send, 1..WIDTH; 0 or >WIDTH is treated as WIDTH.
- data_valid  in  1  word and length are presented.
- data_ready  out  1  feeder can accept a word this cycle.
- out  out  1  serial bit to the detector.
- bit_valid  out  1  `out` carries a payload bit this cycle.
- last_bit  out  1  `out` carries the final bit of the current word.
- busy  out  1  state is SHIFT.
- words_sent  out  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high; clock is clock):
  - state=IDLE, out=IDLE_LEVEL, bit_valid=0, last_bit=0, busy=0, words_sent=0, shift register and bit counter cleared.
  - data_ready=0 while reset is high.
- Outputs: out, bit_valid, last_bit, busy and words_sent are registered. data_ready is combinational: (state==IDLE || last_bit) && !reset.
- Accept: a word is taken at a rising edge when data_valid && data_ready. data_in and the effective length L are captured at that edge. Changes to data_in/len_in afterwards have no effect on the word in flight.
- Latency: the first bit appears on `out`, with bit_valid=1, in the cycle immediately after the accept edge.
- Bit order, MSB_FIRST=1: data_in[L-1], data_in[L-2], ... data_in[0].
- Bit order, MSB_FIRST=0: data_in[0] ... data_in[L-1].
- States:
  - IDLE: out=IDLE_LEVEL, bit_valid=0. On accept, go to SHIFT and load the counter with L-1.
  - SHIFT: one bit per clock, counter decrements. last_bit=1 when the counter is 0 (L=1: first bit is also the last bit).
  - At the edge ending the last_bit cycle:
    - words_sent increments.
    - If data_valid is high, the next word is accepted and its first bit follows with no gap (stay in SHIFT).
    - Otherwise go to IDLE; out returns to IDLE_LEVEL and bit_valid=0 in the next cycle.
- During SHIFT with last_bit=0: data_ready=0, and data_valid is ignored.
- Reset mid-word: the word is abandoned immediately and asynchronously. words_sent is cleared. No partial-word completion is counted.
- No combinational path from data_in or len_in to any output.

Decomposition:
- Shared package fsm_pkg:
  - state typedef (IDLE, SHIFT).
  - function eff_len(len_in, WIDTH) mapping 0 / out-of-range values to WIDTH.
- No sub-module. A single always block holds the FSM and counter; data_ready uses one continuous assignment.

Test Plan:
1. Reset check: assert reset mid-idle and mid-word → out=0, bit_valid=0, words_sent=0, data_ready=0 during reset; data_ready=1 the cycle after release.
2. Single word, WIDTH=8, MSB_FIRST=1, data_in=8'b1011_0010, len=8 → `out` sequence 1,0,1,1,0,0,1,0 on cycles 1..8 after accept; last_bit only on cycle 8; words_sent=1.
3. Back-to-back: word A=8'hA5 len=4, then word B=8'h03 len=2 held valid → out = 0,1,0,1,1,1 contiguous with no idle cycle; data_ready high only in the idle cycle and in the A last_bit cycle; words_sent=2.
4. Length edge cases: len=1 with data_in=1 → one cycle of out=1 with bit_valid=1 and last_bit=1; len=0 → 8 bits sent.
5. Detector integration: feed 10110 through my_fsm → detector output asserts exactly on the cycles predicted by the detector's transition table; a scoreboard compares against a reference model.
6. Wrap and LSB-first: with CNT_W=4, send 17 words → words_sent=1. With MSB_FIRST=0 and data_in=8'h01 len=8 → out = 1 then seven 0s.
